// File: rtl/modbus_scan_master.sv
// modbus_scan_master: periodic Modbus request initiator (RTU, CRC-16) with response timeout and retry.
// Define MODBUS_SCAN_ASCII_EN to add ASCII framing (':' hex LRC CR LF) selected by cfg_ascii_en.
module modbus_scan_master #(
  parameter int RSP_TO_MS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1ms,
  input  logic        cfg_ascii_en,
  input  logic        scan_en,
  input  logic [3:0]  scan_retry_max,
  input  logic [15:0] scan_period_ms,
  input  logic [7:0]  scan_slave,
  input  logic [7:0]  scan_func,
  input  logic [15:0] scan_start_addr,
  input  logic [15:0] scan_qty,
  output logic [7:0]  tx_b,
  output logic        tx_b_v,
  input  logic        tx_b_rdy,
  output logic        tx_sof,
  output logic        tx_eof,
  input  logic        rsp_v,
  input  logic [7:0]  rsp_addr,
  input  logic [7:0]  rsp_func,
  input  logic        rsp_crc_err,
  output logic        busy,
  output logic [15:0] scan_cycles_done,
  output logic [15:0] scan_err_count
);
  // state | meaning: IDLE off | BUILD latch CSRs, fold CRC | SEND stream frame | WAIT_RSP await reply | WAIT_PERIOD pace
  typedef enum logic [2:0] {S_IDLE, S_BUILD, S_SEND, S_WAIT_RSP, S_WAIT_PERIOD} state_t;

  localparam logic [15:0] TO_LIM = 16'(RSP_TO_MS);

  state_t      state, state_nxt;
  logic [7:0]  f_slave, f_func, tx_nxt;
  logic [15:0] f_addr, f_qty, crc, period_cnt, to_cnt;
  logic [4:0]  idx, frame_len;
  logic [3:0]  attempts;
  logic        frame_open, ascii_mode, func_ok, rsp_match;
  logic        start_build, fold, issue, eof_now, retry, done_inc, err_inc;
  logic [7:0]  pl [8];

  function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  assign pl[0] = f_slave;
  assign pl[1] = f_func;
  assign pl[2] = f_addr[15:8];
  assign pl[3] = f_addr[7:0];
  assign pl[4] = f_qty[15:8];
  assign pl[5] = f_qty[7:0];
  assign pl[6] = crc[7:0];
  assign pl[7] = crc[15:8];

  assign func_ok   = (f_func >= 8'd1) && (f_func <= 8'd6);
  assign rsp_match = rsp_v && (rsp_addr == f_slave);
  assign frame_len = ascii_mode ? 5'd17 : 5'd8;
  assign busy      = (state == S_BUILD) || (state == S_SEND) || (state == S_WAIT_RSP);
  assign issue     = (state == S_SEND) && scan_en && tx_b_rdy && !tx_b_v && (idx < frame_len);
  // An abandoned frame still gets its tx_eof so the bridge can close it.
  assign eof_now   = (state == S_SEND) && (scan_en ? (idx == frame_len) : frame_open);

`ifdef MODBUS_SCAN_ASCII_EN
  logic [7:0] lrc_sum, lrc, abyte;
  logic [3:0] am1;

  function automatic logic [7:0] hex_chr(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ascii_mode <= 1'b0;
      lrc_sum    <= 8'h00;
    end else if (start_build) begin
      ascii_mode <= cfg_ascii_en;
      lrc_sum    <= 8'h00;
    end else if (fold) begin
      lrc_sum <= lrc_sum + pl[idx[2:0]];
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = cfg_ascii_en;
  assign ascii_mode = 1'b0;
`endif

  always_comb begin
    tx_nxt = pl[idx[2:0]];
`ifdef MODBUS_SCAN_ASCII_EN
    am1   = idx[3:0] - 4'd1;
    lrc   = 8'h00 - lrc_sum;
    abyte = pl[am1[3:1]];
    if (ascii_mode) begin
      if (idx == 5'd0)       tx_nxt = 8'h3A;
      else if (idx <= 5'd12) tx_nxt = hex_chr(am1[0] ? abyte[3:0] : abyte[7:4]);
      else if (idx == 5'd13) tx_nxt = hex_chr(lrc[7:4]);
      else if (idx == 5'd14) tx_nxt = hex_chr(lrc[3:0]);
      else if (idx == 5'd15) tx_nxt = 8'h0D;
      else                   tx_nxt = 8'h0A;
    end
`endif
  end

  always_comb begin
    state_nxt   = state;
    start_build = 1'b0;
    fold        = 1'b0;
    retry       = 1'b0;
    done_inc    = 1'b0;
    err_inc     = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt   = S_BUILD;
        start_build = 1'b1;
      end
      S_BUILD: begin
        if (!func_ok) begin
          err_inc   = 1'b1;
          state_nxt = S_WAIT_PERIOD;
        end else begin
          fold = 1'b1;
          if (idx == 5'd5) state_nxt = S_SEND;
        end
      end
      S_SEND: if (eof_now) state_nxt = S_WAIT_RSP;
      S_WAIT_RSP: begin
        if (rsp_match && (rsp_func == f_func)) begin
          done_inc  = 1'b1;
          state_nxt = S_WAIT_PERIOD;
        end else if (rsp_match && (rsp_func == (f_func | 8'h80))) begin
          err_inc   = 1'b1;
          state_nxt = S_WAIT_PERIOD;
        end else if (rsp_crc_err || (to_cnt >= TO_LIM)) begin
          if (attempts < scan_retry_max) begin
            retry     = 1'b1;
            state_nxt = S_SEND;
          end else begin
            err_inc   = 1'b1;
            state_nxt = S_WAIT_PERIOD;
          end
        end
      end
      S_WAIT_PERIOD: begin
        if (period_cnt == 16'd0) begin
          state_nxt   = S_BUILD;
          start_build = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!scan_en) begin
      state_nxt   = S_IDLE;
      start_build = 1'b0;
      fold        = 1'b0;
      retry       = 1'b0;
      done_inc    = 1'b0;
      err_inc     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_b <= 8'h00;  tx_b_v <= 1'b0;  tx_sof <= 1'b0;  tx_eof <= 1'b0;
      f_slave <= 8'h00;  f_func <= 8'h00;  f_addr <= 16'h0;  f_qty <= 16'h0;
      crc <= 16'h0;  period_cnt <= 16'h0;  to_cnt <= 16'h0;
      idx <= 5'd0;  attempts <= 4'd0;  frame_open <= 1'b0;
      scan_cycles_done <= 16'h0;  scan_err_count <= 16'h0;
    end else begin
      tx_b_v <= issue;
      tx_sof <= issue && (idx == 5'd0);
      tx_eof <= eof_now;
      if (issue) tx_b <= tx_nxt;
      if (issue && (idx == 5'd0)) frame_open <= 1'b1;
      else if (eof_now)           frame_open <= 1'b0;

      // Period runs from request start, so it is loaded together with the CSR snapshot.
      if (start_build) begin
        f_slave    <= scan_slave;
        f_func     <= scan_func;
        f_addr     <= scan_start_addr;
        f_qty      <= scan_qty;
        period_cnt <= scan_period_ms;
      end else if (tick_1ms && (period_cnt != 16'd0)) begin
        period_cnt <= period_cnt - 16'd1;
      end

      if (start_build) crc <= 16'hFFFF;
      else if (fold)   crc <= crc_fold(crc, pl[idx[2:0]]);

      if (start_build || retry)  idx <= 5'd0;
      else if (fold)             idx <= (idx == 5'd5) ? 5'd0 : idx + 5'd1;
      else if (issue)            idx <= idx + 5'd1;

      if ((state == S_SEND) && (state_nxt == S_WAIT_RSP)) to_cnt <= 16'h0;
      else if ((state == S_WAIT_RSP) && tick_1ms)         to_cnt <= to_cnt + 16'd1;

      if (retry) attempts <= attempts + 4'd1;
      else if ((state == S_WAIT_PERIOD) || (state == S_IDLE)) attempts <= 4'd0;

      if (done_inc) scan_cycles_done <= scan_cycles_done + 16'd1;
      if (err_inc)  scan_err_count   <= scan_err_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_modbus_scan_master.sv
// tb_modbus_scan_master: scoreboard bench; expected tx bytes are queued per request and popped as the DUT emits them.
`timescale 1ns/1ps
module tb_modbus_scan_master;
  localparam int RSP_TO = 100;
  localparam int TICK_P = 20;

  logic        clk = 1'b0, rst = 1'b1, tick_1ms = 1'b0, cfg_ascii_en = 1'b0, scan_en = 1'b0;
  logic [3:0]  scan_retry_max = 4'd0;
  logic [15:0] scan_period_ms = 16'd1000, scan_start_addr = 16'h0, scan_qty = 16'h0;
  logic [7:0]  scan_slave = 8'h00, scan_func = 8'h00;
  logic        tx_b_rdy = 1'b1, rsp_v = 1'b0, rsp_crc_err = 1'b0;
  logic [7:0]  rsp_addr = 8'h00, rsp_func = 8'h00;
  logic [7:0]  tx_b;
  logic        tx_b_v, tx_sof, tx_eof, busy;
  logic [15:0] scan_cycles_done, scan_err_count;

  modbus_scan_master #(.RSP_TO_MS(RSP_TO)) dut (
    .clk(clk), .rst(rst), .tick_1ms(tick_1ms), .cfg_ascii_en(cfg_ascii_en), .scan_en(scan_en),
    .scan_retry_max(scan_retry_max), .scan_period_ms(scan_period_ms), .scan_slave(scan_slave),
    .scan_func(scan_func), .scan_start_addr(scan_start_addr), .scan_qty(scan_qty),
    .tx_b(tx_b), .tx_b_v(tx_b_v), .tx_b_rdy(tx_b_rdy), .tx_sof(tx_sof), .tx_eof(tx_eof),
    .rsp_v(rsp_v), .rsp_addr(rsp_addr), .rsp_func(rsp_func), .rsp_crc_err(rsp_crc_err),
    .busy(busy), .scan_cycles_done(scan_cycles_done), .scan_err_count(scan_err_count)
  );

  int n_tests = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  int sof_cnt = 0, eof_cnt = 0, pos = 0, cyc = 0;
  int tk_since_sof = 0, tk_since_eof = 0, gap_sof = 0, gap_eof = 0, sof_time = 0, sof_span = 0;
  int exp_done = 0, exp_err = 0;

  always #5 clk = ~clk;

  initial forever begin
    repeat (TICK_P - 1) @(posedge clk);
    #1 tick_1ms = 1'b1;
    @(posedge clk);
    #1 tick_1ms = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pos = 0;
    end else begin
      if (tx_b_v) begin
        if (exp_q.size() == 0) chk("tx_extra_byte", 32'(tx_b) | 32'h100, 32'h0);
        else chk("tx_b", 32'(tx_b), 32'(exp_q.pop_front()));
        chk("tx_sof_align", 32'(tx_sof), (pos == 0) ? 32'd1 : 32'd0);
        pos++;
      end
      if (tx_sof) begin
        sof_cnt++;
        gap_sof = tk_since_sof;  tk_since_sof = 0;
        gap_eof = tk_since_eof;
        sof_span = cyc - sof_time;  sof_time = cyc;
      end
      if (tx_eof) begin
        eof_cnt++;
        pos = 0;
        tk_since_eof = 0;
      end
      if (tick_1ms) begin
        tk_since_sof++;
        tk_since_eof++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_eof(input int n, input string tag);
    int k;
    k = 0;
    while (eof_cnt < n && k < 5000) begin step(); k++; end
    if (eof_cnt < n) chk({tag, "_eof_timeout"}, 32'(eof_cnt), 32'(n));
  endtask

  task automatic set_csr(input logic [7:0] sl, input logic [7:0] fc, input logic [15:0] ad, input logic [15:0] qt);
    scan_slave = sl;  scan_func = fc;  scan_start_addr = ad;  scan_qty = qt;
  endtask

  task automatic push_lit(input logic [63:0] f);
    for (int i = 7; i >= 0; i--) exp_q.push_back(f[i*8 +: 8]);
  endtask

  task automatic push_rtu(input logic [7:0] sl, input logic [7:0] fc, input logic [15:0] ad, input logic [15:0] qt);
    logic [7:0]  b [6];
    logic [15:0] c;
    b = '{sl, fc, ad[15:8], ad[7:0], qt[15:8], qt[7:0]};
    c = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      c = c ^ {8'h00, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    for (int i = 0; i < 6; i++) exp_q.push_back(b[i]);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
  endtask

  task automatic pulse_rsp(input logic [7:0] a, input logic [7:0] f, input logic v, input logic e);
    rsp_addr = a;  rsp_func = f;  rsp_v = v;  rsp_crc_err = e;
    step();
    rsp_v = 1'b0;  rsp_crc_err = 1'b0;
  endtask

  task automatic stop_scan();
    scan_en = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    int s0, e0, eb, k;
    logic [15:0] err0;
    repeat (3) step();
    chk("rst_tx_b_v", 32'(tx_b_v), 0);
    chk("rst_tx_sof", 32'(tx_sof), 0);
    chk("rst_tx_eof", 32'(tx_eof), 0);
    chk("rst_tx_b", 32'(tx_b), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(scan_cycles_done), 0);
    chk("rst_err", 32'(scan_err_count), 0);
    rst = 1'b0;
    repeat (2) step();

    // T1: read holding registers frame
    set_csr(8'h11, 8'h03, 16'h006B, 16'h0003);
    push_lit(64'h1103006B00037687);
    s0 = sof_cnt;  e0 = eof_cnt;
    scan_en = 1'b1;
    step();
    chk("t1_busy_start", 32'(busy), 1);
    wait_eof(e0 + 1, "t1");
    chk("t1_sof_once", 32'(sof_cnt - s0), 1);
    pulse_rsp(8'h11, 8'h03, 1'b1, 1'b0);  exp_done++;
    chk("t1_done", 32'(scan_cycles_done), 32'(exp_done));
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_q_empty", 32'(exp_q.size()), 0);
    stop_scan();
    chk("t1_eof_once", 32'(eof_cnt - e0), 1);

    // T2: write single register; a foreign response is ignored first
    set_csr(8'h11, 8'h06, 16'h0001, 16'h0003);
    push_lit(64'h110600010003_9A9B);
    e0 = eof_cnt;
    scan_en = 1'b1;
    wait_eof(e0 + 1, "t2");
    pulse_rsp(8'h12, 8'h06, 1'b1, 1'b0);
    chk("t2_ignore_busy", 32'(busy), 1);
    chk("t2_ignore_done", 32'(scan_cycles_done), 32'(exp_done));
    pulse_rsp(8'h11, 8'h06, 1'b1, 1'b0);  exp_done++;
    chk("t2_done", 32'(scan_cycles_done), 32'(exp_done));
    stop_scan();

    // T3: no response, two retries, each spaced by the response timeout
    set_csr(8'h22, 8'h04, 16'h0010, 16'h0002);
    scan_retry_max = 4'd2;
    repeat (3) push_rtu(8'h22, 8'h04, 16'h0010, 16'h0002);
    s0 = sof_cnt;  e0 = eof_cnt;  err0 = scan_err_count;
    scan_en = 1'b1;
    wait_eof(e0 + 1, "t3_a0");
    for (int a = 1; a <= 2; a++) begin
      wait_eof(e0 + a + 1, "t3_retry");
      chk("t3_to_gap", 32'(gap_eof), 32'(RSP_TO));
    end
    k = 0;
    while (scan_err_count == err0 && k < 3000) begin step(); k++; end
    exp_err++;
    chk("t3_err", 32'(scan_err_count), 32'(exp_err));
    chk("t3_done_same", 32'(scan_cycles_done), 32'(exp_done));
    chk("t3_frames", 32'(sof_cnt - s0), 3);
    chk("t3_q_empty", 32'(exp_q.size()), 0);
    chk("t3_busy", 32'(busy), 0);
    stop_scan();

    // T4: CRC error -> resend; simultaneous rsp_v and crc_err -> success; then exception reply
    set_csr(8'h11, 8'h03, 16'h006B, 16'h0003);
    repeat (2) push_lit(64'h1103006B00037687);
    s0 = sof_cnt;  e0 = eof_cnt;
    scan_en = 1'b1;
    wait_eof(e0 + 1, "t4_a0");
    pulse_rsp(8'h00, 8'h00, 1'b0, 1'b1);
    wait_eof(e0 + 2, "t4_a1");
    pulse_rsp(8'h11, 8'h03, 1'b1, 1'b1);  exp_done++;
    chk("t4_done", 32'(scan_cycles_done), 32'(exp_done));
    chk("t4_err_same", 32'(scan_err_count), 32'(exp_err));
    chk("t4_frames", 32'(sof_cnt - s0), 2);
    stop_scan();
    push_lit(64'h1103006B00037687);
    s0 = sof_cnt;  e0 = eof_cnt;
    scan_en = 1'b1;
    wait_eof(e0 + 1, "t4_exc");
    pulse_rsp(8'h11, 8'h83, 1'b1, 1'b0);  exp_err++;
    chk("t4_exc_err", 32'(scan_err_count), 32'(exp_err));
    repeat (300) step();
    chk("t4_exc_no_resend", 32'(sof_cnt - s0), 1);
    chk("t4_exc_busy", 32'(busy), 0);
    stop_scan();

    // T5: 5 ms start-to-start pacing, then abandon a frame mid-send
    set_csr(8'h05, 8'h01, 16'h0000, 16'h000A);
    scan_period_ms = 16'd5;
    scan_retry_max = 4'd0;
    repeat (5) push_rtu(8'h05, 8'h01, 16'h0000, 16'h000A);
    s0 = sof_cnt;  e0 = eof_cnt;
    scan_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_eof(e0 + r + 1, "t5");
      if (r >= 2) begin
        chk("t5_tick_gap", 32'(gap_sof), 5);
        chk("t5_cycle_gap", 32'(sof_span), 32'(5 * TICK_P));
      end
      pulse_rsp(8'h05, 8'h01, 1'b1, 1'b0);  exp_done++;
    end
    k = 0;
    while (!((sof_cnt - s0 == 5) && (pos == 3)) && k < 3000) begin step(); k++; end
    if (k >= 3000) chk("t5_abort_wait_timeout", 32'(pos), 3);
    scan_en = 1'b0;
    eb = eof_cnt;
    repeat (10) step();
    chk("t5_abort_eof", 32'(eof_cnt - eb), 1);
    chk("t5_abort_busy", 32'(busy), 0);
    chk("t5_abort_left", 32'(exp_q.size()), 5);
    chk("t5_done", 32'(scan_cycles_done), 32'(exp_done));
    exp_q.delete();
    scan_period_ms = 16'd1000;

    // T6: unsupported function code -> error, no frame
    set_csr(8'h11, 8'h07, 16'h006B, 16'h0003);
    s0 = sof_cnt;
    scan_en = 1'b1;
    repeat (20) step();
    exp_err++;
    chk("t6_bad_func_err", 32'(scan_err_count), 32'(exp_err));
    chk("t6_bad_func_nosof", 32'(sof_cnt - s0), 0);
    chk("t6_bad_func_busy", 32'(busy), 0);
    stop_scan();

`ifdef MODBUS_SCAN_ASCII_EN
    begin
      string s;
      s = ":1103006B00037E\r\n";
      set_csr(8'h11, 8'h03, 16'h006B, 16'h0003);
      cfg_ascii_en = 1'b1;
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      e0 = eof_cnt;
      scan_en = 1'b1;
      wait_eof(e0 + 1, "t6_ascii");
      pulse_rsp(8'h11, 8'h03, 1'b1, 1'b0);  exp_done++;
      chk("t6_ascii_done", 32'(scan_cycles_done), 32'(exp_done));
      chk("t6_ascii_q_empty", 32'(exp_q.size()), 0);
      stop_scan();
      cfg_ascii_en = 1'b0;
    end
`endif

    // Asynchronous reset in the middle of a frame
    set_csr(8'h11, 8'h03, 16'h006B, 16'h0003);
    push_lit(64'h1103006B00037687);
    scan_en = 1'b1;
    k = 0;
    while (pos != 2 && k < 100) begin step(); k++; end
    if (k >= 100) chk("arst_wait_timeout", 32'(pos), 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_b_v", 32'(tx_b_v), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(scan_cycles_done), 0);
    chk("arst_err", 32'(scan_err_count), 0);
    eb = eof_cnt;
    scan_en = 1'b0;
    repeat (5) step();
    chk("arst_no_eof", 32'(eof_cnt - eb), 0);
    exp_q.delete();
    rst = 1'b0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
